// File: rtl/mb_port_initiator.sv
// rtl/mb_port_initiator.sv - requester engine for one port of the multi-bank dual-port memory
//
// Purpose: accepts one read/write request at a time from the host, drives the
// memory port for exactly one cycle, waits the port's fixed latency, then
// presents a response until the host accepts it.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             host request handshake (ready only in IDLE)
//   req_wr, req_addr, req_wdata     request type, address, write data
//   rsp_valid/rsp_ready             host response handshake
//   rsp_wr, rsp_rdata, rsp_err      response type echo, read data (0 for writes), error
//   mem_en, mem_we                  one-cycle access strobe and its write enable
//   mem_addr, mem_bank, mem_wdata   memory address, bank (upper 2 address bits), write data
//   mem_rdata, mem_rvalid           memory read data and its valid flag
//   busy                            high whenever not in IDLE
//
// Optional feature: define MB_INIT_RVALID_CHK_EN to flag reads whose
// mem_rvalid does not line up with the fixed read latency (rsp_err).
// Without it, mem_rvalid is ignored and rsp_err is tied low.

module mb_port_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(4 * MEM_DEPTH),
  parameter int WR_LATENCY = 10,
  parameter int RD_LATENCY = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_bank,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  busy
);

  localparam int MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_wr;

`ifndef MB_INIT_RVALID_CHK_EN
  logic unused_rvalid;
  assign unused_rvalid = mem_rvalid;
  assign rsp_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_bank  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
`ifdef MB_INIT_RVALID_CHK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // req_ready is registered high in IDLE, so req_valid alone completes the handshake.
          // The memory-side outputs are loaded here so they are live during the ISSUE cycle.
          if (req_valid) begin
            lat_wr    <= req_wr;
            mem_en    <= 1'b1;
            mem_we    <= req_wr;
            mem_addr  <= req_addr;
            mem_bank  <= req_addr[ADDR_WIDTH-1 -: 2];
            mem_wdata <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef MB_INIT_RVALID_CHK_EN
            rsp_err   <= 1'b0;
`endif
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          mem_en <= 1'b0;
          cnt    <= lat_wr ? WR_LOAD : RD_LOAD;
          state  <= WAIT;
        end

        WAIT: begin
          // cnt reaches 0 in the cycle where read data is due (issue cycle + latency)
          if (cnt == '0) begin
            rsp_rdata <= lat_wr ? '0 : mem_rdata;
            rsp_wr    <= lat_wr;
            rsp_valid <= 1'b1;
`ifdef MB_INIT_RVALID_CHK_EN
            if (!lat_wr && !mem_rvalid) rsp_err <= 1'b1;
`endif
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_ONE;
`ifdef MB_INIT_RVALID_CHK_EN
            // rvalid arriving before the latency expires is sticky for this read
            if (!lat_wr && mem_rvalid) rsp_err <= 1'b1;
`endif
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_port_initiator.sv
// tb/tb_mb_port_initiator.sv - self-checking bench for mb_port_initiator (port A 10/5, port B 7/8)

module tb_mb_port_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_wr    [2];
  logic [5:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic       rsp_wr    [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err   [2];
  logic       mem_en    [2];
  logic       mem_we    [2];
  logic [5:0] mem_addr  [2];
  logic [1:0] mem_bank  [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];
  logic       mem_rvalid[2];
  logic       busy      [2];

  for (genvar g = 0; g < 2; g++) begin : g_port
    mb_port_initiator #(
      .DATA_WIDTH(8),
      .MEM_DEPTH (16),
      .ADDR_WIDTH(6),
      .WR_LATENCY((g == 0) ? 10 : 7),
      .RD_LATENCY((g == 0) ? 5 : 8)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wr    (req_wr[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_wr    (rsp_wr[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_bank  (mem_bank[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .mem_rvalid(mem_rvalid[g]),
      .busy      (busy[g])
    );
  end

  function automatic int wr_lat(input int p);
    return (p == 0) ? 10 : 7;
  endfunction

  function automatic int rd_lat(input int p);
    return (p == 0) ? 5 : 8;
  endfunction

`ifdef MB_INIT_RVALID_CHK_EN
  localparam logic EARLY_ERR = 1'b1;
`else
  localparam logic EARLY_ERR = 1'b0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    int         port;
    logic       wr;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  // Memory model: stores writes, returns stored data exactly rd_lat cycles after the
  // issue cycle; rvalid pulses rv_off cycles before the data (0 = aligned).
  logic [7:0] mem [2][64];
  int         pend [2];
  logic [7:0] pdata [2];
  int         rv_off [2];
  int         mem_en_cnt [2];

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pdata[p] = 8'h00; rv_off[p] = 0; mem_en_cnt[p] = 0;
      mem_rdata[p] = 8'hEE; mem_rvalid[p] = 1'b0;
      for (int a = 0; a < 64; a++) mem[p][a] = 8'(a);
      mem[p][6'h3F] = 8'h5C;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        mem_rdata[p]  = 8'hEE;
        mem_rvalid[p] = 1'b0;
        if (pend[p] > 0) begin
          pend[p]--;
          if (pend[p] == rv_off[p]) mem_rvalid[p] = 1'b1;
          if (pend[p] == 0) mem_rdata[p] = pdata[p];
        end
        if (mem_en[p] === 1'b1) begin
          mem_en_cnt[p]++;
          if (mem_we[p]) mem[p][mem_addr[p]] = mem_wdata[p];
          else begin
            pend[p]  = rd_lat(p);
            pdata[p] = mem[p][mem_addr[p]];
          end
        end
      end
    end
  end

  // Response monitor: a rise of rsp_valid must coincide with the head entry's due cycle.
  logic prev_v [2];
  initial begin
    logic rise, due;
    exp_t e;
    prev_v[0] = 1'b0;
    prev_v[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        rise = (rsp_valid[p] === 1'b1) && !prev_v[p];
        due  = (sbq.size() > 0) && (sbq[0].port == p) && (sbq[0].cyc == cyc);
        if (rise || due) begin
          check($sformatf("p%0d rsp_valid_rise cyc%0d", p, cyc), rise, due);
          if (rise && due) begin
            e = sbq.pop_front();
            check($sformatf("p%0d rsp_wr", p), rsp_wr[p], e.wr);
            check($sformatf("p%0d rsp_rdata", p), rsp_rdata[p], e.rdata);
            check($sformatf("p%0d rsp_err", p), rsp_err[p], e.err);
          end
        end
        prev_v[p] = (rsp_valid[p] === 1'b1);
      end
    end
  end

  task automatic do_req(input int p, input logic wr, input logic [5:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input logic exp_err, input logic keep);
    int   budget;
    int   n;
    exp_t e;
    budget       = 0;
    req_valid[p] = 1'b1;
    req_wr[p]    = wr;
    req_addr[p]  = addr;
    req_wdata[p] = wd;
    while (req_ready[p] !== 1'b1 && budget < 40) begin
      tick();
      budget++;
    end
    check($sformatf("p%0d req_ready_accept", p), req_ready[p], 1'b1);
    n       = cyc;
    e.port  = p;
    e.wr    = wr;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = n + (wr ? wr_lat(p) : rd_lat(p)) + 2;
    sbq.push_back(e);
    tick();
    if (!keep) req_valid[p] = 1'b0;
    check($sformatf("p%0d issue mem_en", p), mem_en[p], 1'b1);
    check($sformatf("p%0d issue mem_we", p), mem_we[p], wr);
    check($sformatf("p%0d issue mem_addr", p), mem_addr[p], addr);
    check($sformatf("p%0d issue mem_bank", p), mem_bank[p], addr[5:4]);
    check($sformatf("p%0d issue mem_wdata", p), mem_wdata[p], wd);
    check($sformatf("p%0d issue busy", p), busy[p], 1'b1);
    check($sformatf("p%0d issue req_ready", p), req_ready[p], 1'b0);
    tick();
    check($sformatf("p%0d post_issue mem_en", p), mem_en[p], 1'b0);
  endtask

  task automatic wait_rsp();
    int budget;
    budget = 0;
    while (sbq.size() != 0 && budget < 60) begin
      tick();
      budget++;
    end
    check("rsp_drain", sbq.size(), 0);
  endtask

  task automatic finish_rsp(input int p);
    tick();
    check($sformatf("p%0d rsp_valid_drop", p), rsp_valid[p], 1'b0);
    check($sformatf("p%0d back_idle req_ready", p), req_ready[p], 1'b1);
    check($sformatf("p%0d back_idle busy", p), busy[p], 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  base;
    logic saw_v;

    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0; req_wr[p] = 1'b0; req_addr[p] = 6'h00; req_wdata[p] = 8'h00;
      rsp_ready[p] = 1'b1;
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    for (int p = 0; p < 2; p++) begin
      check($sformatf("p%0d reset req_ready", p), req_ready[p], 1'b1);
      check($sformatf("p%0d reset mem_en", p), mem_en[p], 1'b0);
      check($sformatf("p%0d reset rsp_valid", p), rsp_valid[p], 1'b0);
      check($sformatf("p%0d reset busy", p), busy[p], 1'b0);
      check($sformatf("p%0d reset rsp_rdata", p), rsp_rdata[p], 8'h00);
      check($sformatf("p%0d reset rsp_err", p), rsp_err[p], 1'b0);
      check($sformatf("p%0d reset mem_addr", p), mem_addr[p], 6'h00);
    end

    // Port A: write, reads, write after read
    do_req(0, 1'b1, 6'h25, 8'hA5, 8'h00, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(0);
    do_req(0, 1'b0, 6'h3F, 8'h11, 8'h5C, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(0);
    do_req(0, 1'b0, 6'h25, 8'h22, 8'hA5, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(0);
    do_req(0, 1'b1, 6'h01, 8'h77, 8'h00, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(0);

    // Port A: response held with rsp_ready low while a second request waits
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 6'h3F, 8'h00, 8'h5C, 1'b0, 1'b1);
    req_addr[0] = 6'h25;
    wait_rsp();
    base = mem_en_cnt[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold rsp_valid", rsp_valid[0], 1'b1);
      check("hold rsp_rdata", rsp_rdata[0], 8'h5C);
      check("hold req_ready", req_ready[0], 1'b0);
    end
    rsp_ready[0] = 1'b1;
    tick();
    check("hold release req_ready", req_ready[0], 1'b1);
    check("hold release rsp_valid", rsp_valid[0], 1'b0);
    begin
      exp_t e;
      e.port = 0; e.wr = 1'b0; e.rdata = 8'hA5; e.err = 1'b0; e.cyc = cyc + 5 + 2;
      sbq.push_back(e);
    end
    tick();
    req_valid[0] = 1'b0;
    check("queued issue mem_en", mem_en[0], 1'b1);
    check("queued issue mem_addr", mem_addr[0], 6'h25);
    check("hold mem_en pulse count", mem_en_cnt[0], base + 1);
    wait_rsp(); finish_rsp(0);

    // Port A: reset in cycle T+2 of a read abandons it
    do_req(0, 1'b0, 6'h3F, 8'h00, 8'h5C, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    sbq.delete();
    tick();
    rst = 1'b0;
    check("abort req_ready", req_ready[0], 1'b1);
    check("abort busy", busy[0], 1'b0);
    check("abort mem_en", mem_en[0], 1'b0);
    check("abort rsp_valid", rsp_valid[0], 1'b0);
    saw_v = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rsp_valid[0] !== 1'b0) saw_v = 1'b1;
    end
    check("abort no_rsp", saw_v, 1'b0);
    do_req(0, 1'b0, 6'h3F, 8'h00, 8'h5C, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(0);

    // Port B (WR 7, RD 8): latencies and rvalid alignment
    do_req(1, 1'b1, 6'h10, 8'h3C, 8'h00, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(1);
    do_req(1, 1'b0, 6'h10, 8'h00, 8'h3C, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(1);
    rv_off[1] = 1;
    do_req(1, 1'b0, 6'h3F, 8'h00, 8'h5C, EARLY_ERR, 1'b0);
    wait_rsp(); finish_rsp(1);
    rv_off[1] = 0;
    do_req(1, 1'b0, 6'h3F, 8'h00, 8'h5C, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(1);
    do_req(1, 1'b1, 6'h3F, 8'h9D, 8'h00, 1'b0, 1'b0);
    wait_rsp(); finish_rsp(1);

    repeat (3) tick();
    check("mem_en total A", mem_en_cnt[0], 8);
    check("mem_en total B", mem_en_cnt[1], 5);
    check("sb empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
